// File: rtl/mem_wb_stage.sv
// mem_wb_stage: write-back end of the pipeline, fed by the EX/M register.
//   ALU results are written to the register file one cycle after they are
//   presented. Loads are checked for alignment and size. A legal load runs
//   one request/response transaction on the data-memory port. The returned
//   word is narrowed to a byte or half and extended before it is written.
//   stall is high whenever a load is in flight, so upstream holds the next
//   instruction.
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   rd_addr_in, rd_in      destination register; ALU result or load address
//   writeback_en_in        instruction writes rd
//   writeback_from_mem_in  instruction is a load
//   funct3_in              load size (LB/LH/LW/LBU/LHU)
//   stall                  upstream hold request
//   dmem_req_valid/ready   load request handshake, dmem_addr word-aligned
//   dmem_resp_valid/data   read response
//   rf_we/rf_waddr/rf_wdata register-file write port (1-cycle write pulse)
//   load_fault             1-cycle pulse on a misaligned or illegal-size load
module mem_wb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_in,
  input  logic [31:0]       rd_in,
  input  logic              writeback_en_in,
  input  logic              writeback_from_mem_in,
  input  logic [2:0]        funct3_in,
  output logic              stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_resp_valid,
  input  logic [31:0]       dmem_resp_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              load_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Returns 1 when the load size is illegal or the address is misaligned for it.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3)
      3'd0, 3'd4: bad = 1'b0;
      3'd1, 3'd5: bad = lane[0];
      3'd2:       bad = (lane != 2'd0);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Selects the addressed byte or half of the read word and extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    res_v = {{24{byte_v[7]}}, byte_v};
      3'd1:    res_v = {{16{half_v[15]}}, half_v};
      3'd2:    res_v = word;
      3'd4:    res_v = {24'h00_0000, byte_v};
      3'd5:    res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [4:0]          ld_rd_r;
  logic [1:0]          ld_lane_r;
  logic [2:0]          ld_f3_r;
  logic [ADDR_W-1:0]   dmem_addr_r;
  logic                rf_we_r, rf_we_nxt_s;
  logic [4:0]          rf_waddr_r, rf_waddr_nxt_s;
  logic [31:0]         rf_wdata_r, rf_wdata_nxt_s;
  logic                load_fault_r, load_fault_nxt_s;
  logic                is_load_s, fault_s, accept_s;

  // A load is only real when it also writes back; faulty loads never issue.
  assign is_load_s = writeback_en_in && writeback_from_mem_in;
  assign fault_s   = is_load_s && load_bad(funct3_in, rd_in[1:0]);
  assign accept_s  = is_load_s && !fault_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic for the load transaction.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_REQ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_req_ready) state_nxt_s = ST_WAIT;
        else                state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (dmem_resp_valid) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered write-port and fault outputs.
  always_comb begin
    rf_we_nxt_s      = 1'b0;
    rf_waddr_nxt_s   = rf_waddr_r;
    rf_wdata_nxt_s   = rf_wdata_r;
    load_fault_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!writeback_from_mem_in) begin
          rf_we_nxt_s    = writeback_en_in && (rd_addr_in != 5'd0);
          rf_waddr_nxt_s = rd_addr_in;
          rf_wdata_nxt_s = rd_in;
        end else begin
          load_fault_nxt_s = fault_s;
        end
      end
      ST_WAIT: begin
        if (dmem_resp_valid) begin
          rf_we_nxt_s    = (ld_rd_r != 5'd0);
          rf_waddr_nxt_s = ld_rd_r;
          rf_wdata_nxt_s = load_extract(dmem_resp_data, ld_lane_r, ld_f3_r);
        end else begin
          rf_we_nxt_s = 1'b0;
        end
      end
      ST_REQ:  rf_we_nxt_s = 1'b0;
      default: rf_we_nxt_s = 1'b0;
    endcase
  end

  // Output registers and the load context captured when a load is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= 5'd0;
      rf_wdata_r   <= 32'h0000_0000;
      load_fault_r <= 1'b0;
      ld_rd_r      <= 5'd0;
      ld_lane_r    <= 2'd0;
      ld_f3_r      <= 3'd0;
      dmem_addr_r  <= '0;
    end else begin
      rf_we_r      <= rf_we_nxt_s;
      rf_waddr_r   <= rf_waddr_nxt_s;
      rf_wdata_r   <= rf_wdata_nxt_s;
      load_fault_r <= load_fault_nxt_s;
      if ((state_r == ST_IDLE) && accept_s) begin
        ld_rd_r     <= rd_addr_in;
        ld_lane_r   <= rd_in[1:0];
        ld_f3_r     <= funct3_in;
        dmem_addr_r <= {rd_in[ADDR_W-1:2], 2'b00};
      end else begin
        ld_rd_r     <= ld_rd_r;
        ld_lane_r   <= ld_lane_r;
        ld_f3_r     <= ld_f3_r;
        dmem_addr_r <= dmem_addr_r;
      end
    end
  end

  assign stall          = (state_r != ST_IDLE);
  assign dmem_req_valid = (state_r == ST_REQ);
  assign dmem_addr      = dmem_addr_r;
  assign rf_we          = rf_we_r;
  assign rf_waddr       = rf_waddr_r;
  assign rf_wdata       = rf_wdata_r;
  assign load_fault     = load_fault_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases followed by a random
// instruction stream, with a small reference model for fault/extract rules.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_in;
  logic        writeback_en_in;
  logic        writeback_from_mem_in;
  logic [2:0]  funct3_in;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_fault;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_in(rd_addr_in), .rd_in(rd_in),
    .writeback_en_in(writeback_en_in),
    .writeback_from_mem_in(writeback_from_mem_in),
    .funct3_in(funct3_in), .stall(stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .load_fault(load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: does this load size/address combination fault?
  function automatic bit ref_bad(input int f3, input logic [31:0] addr);
    int off;
    off = int'(addr % 32'd4);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2) != 0) return 1'b1;
    if (f3 == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: loaded value computed by shifting and arithmetic extension.
  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] v;
    int off;
    off = int'(addr % 32'd4);
    if (f3 == 2) return word;
    if (f3 == 0 || f3 == 4) begin
      v = (word >> (8 * off)) & 32'h0000_00FF;
      if (f3 == 0 && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = (word >> (8 * off)) & 32'h0000_FFFF;
      if (f3 == 1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Random instruction bits presented while the stage is stalled (must be ignored).
  task automatic rand_held();
    rd_addr_in            = 5'($urandom);
    rd_in                 = $urandom;
    writeback_en_in       = 1'($urandom);
    writeback_from_mem_in = 1'($urandom);
    funct3_in             = 3'($urandom);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input bit en, input bit from_mem);
    rd_addr_in = rd; rd_in = val; writeback_en_in = en;
    writeback_from_mem_in = from_mem; funct3_in = 3'($urandom);
    dmem_req_ready = 1'($urandom); dmem_resp_valid = 1'($urandom);
    dmem_resp_data = $urandom;
    @(negedge clk);
    check_val("alu_we", rf_we, (en && !from_mem && rd != 5'd0));
    if (!from_mem) begin
      check_val("alu_waddr", rf_waddr, rd);
      check_val("alu_wdata", rf_wdata, val);
    end
    check_val("alu_stall", stall, 1'b0);
    check_val("alu_req", dmem_req_valid, 1'b0);
    check_val("alu_fault", load_fault, 1'b0);
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [31:0] addr, input int f3,
                         input int rdy_dly, input int resp_dly, input logic [31:0] word);
    rd_addr_in = rd; rd_in = addr; writeback_en_in = 1'b1;
    writeback_from_mem_in = 1'b1; funct3_in = 3'(f3);
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    @(negedge clk);
    if (ref_bad(f3, addr)) begin
      check_val("flt_pulse", load_fault, 1'b1);
      check_val("flt_we", rf_we, 1'b0);
      check_val("flt_stall", stall, 1'b0);
      check_val("flt_req", dmem_req_valid, 1'b0);
      writeback_en_in = 1'b0; writeback_from_mem_in = 1'b0;
      @(negedge clk);
      check_val("flt_clear", load_fault, 1'b0);
      check_val("flt_req2", dmem_req_valid, 1'b0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      check_val("req_stall", stall, 1'b1);
      check_val("req_valid", dmem_req_valid, 1'b1);
      check_val("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_val("req_we", rf_we, 1'b0);
      rand_held();
      dmem_req_ready  = (i == rdy_dly);
      dmem_resp_valid = 1'($urandom);
      dmem_resp_data  = $urandom;
      @(negedge clk);
    end
    for (int i = 0; i <= resp_dly; i++) begin
      check_val("wait_stall", stall, 1'b1);
      check_val("wait_req", dmem_req_valid, 1'b0);
      check_val("wait_we", rf_we, 1'b0);
      rand_held();
      dmem_req_ready  = 1'($urandom);
      dmem_resp_valid = (i == resp_dly);
      dmem_resp_data  = (i == resp_dly) ? word : $urandom;
      @(negedge clk);
    end
    check_val("ld_we", rf_we, (rd != 5'd0));
    if (rd != 5'd0) begin
      check_val("ld_waddr", rf_waddr, rd);
      check_val("ld_wdata", rf_wdata, ref_load(f3, addr, word));
    end
    check_val("ld_stall", stall, 1'b0);
    check_val("ld_fault", load_fault, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_stall"}, stall, 1'b0);
    check_val({tag, "_req"}, dmem_req_valid, 1'b0);
    check_val({tag, "_addr"}, dmem_addr, 32'h0);
    check_val({tag, "_we"}, rf_we, 1'b0);
    check_val({tag, "_waddr"}, rf_waddr, 5'd0);
    check_val({tag, "_wdata"}, rf_wdata, 32'h0);
    check_val({tag, "_fault"}, load_fault, 1'b0);
  endtask

  // Reset while a load is in REQ (in_wait=0) or WAIT (in_wait=1), then a stale response.
  task automatic reset_mid(input bit in_wait);
    rd_addr_in = 5'd7; rd_in = 32'h0000_0200; writeback_en_in = 1'b1;
    writeback_from_mem_in = 1'b1; funct3_in = 3'd2;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    @(negedge clk);
    check_val("rm_stall", stall, 1'b1);
    if (in_wait) begin
      dmem_req_ready = 1'b1;
      @(negedge clk);
      check_val("rm_wait_req", dmem_req_valid, 1'b0);
    end
    dmem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rm_rst");
    rst = 1'b1;
    writeback_en_in = 1'b0; writeback_from_mem_in = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_data = $urandom;
    @(negedge clk);
    check_val("rm_stale_we", rf_we, 1'b0);
    check_val("rm_stale_stall", stall, 1'b0);
    check_val("rm_stale_req", dmem_req_valid, 1'b0);
    dmem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rand_held();
    writeback_en_in = 1'b1;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_data = $urandom;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // Directed cases
    alu_op(5'd5, 32'h0000_1234, 1'b1, 1'b0);
    alu_op(5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    alu_op(5'd9, 32'hCAFE_0001, 1'b0, 1'b0);
    alu_op(5'd9, 32'h0000_0104, 1'b0, 1'b1);
    load_op(5'd3, 32'h0000_0103, 0, 0, 0, 32'h80FF_1122);
    load_op(5'd4, 32'h0000_0102, 5, 3, 0, 32'h8001_0000);
    load_op(5'd6, 32'h0000_0101, 2, 0, 0, 32'h1234_5678);
    alu_op(5'd8, 32'h0BAD_F00D, 1'b1, 1'b0);
    load_op(5'd10, 32'h0000_0302, 1, 1, 2, 32'h9ABC_DEF0);
    load_op(5'd11, 32'h0000_0400, 7, 0, 0, 32'h0);
    load_op(5'd0, 32'h0000_0500, 2, 0, 0, 32'h5555_AAAA);
    reset_mid(1'b1);
    reset_mid(1'b0);

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: alu_op(5'($urandom), $urandom, 1'($urandom), 1'b0);
        1: alu_op(5'($urandom), $urandom, 1'b0, 1'b1);
        default: load_op(5'($urandom), $urandom, int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
